// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard transmitter.
// Holds the event FSM states, the frame constants and the parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP,
    ST_HOLD
  } state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam int         FRAME_BITS = 11;

  // Parity bit that makes the total count of ones (data plus parity) odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_frame_ser.sv
// Serializes one byte into an 11-bit PS/2 frame and generates the device clock.
// Each bit is CLK_DIV cycles with the clock high, then CLK_DIV cycles with it low.
module ps2_frame_ser
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] data,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       stop_low,
  output logic       done
);

  localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

  logic        active_q;
  logic        low_q;
  logic [3:0]  bit_idx;
  logic [11:0] div_cnt;
  logic [10:0] frame_q;
  logic        div_end;

  assign div_end  = (div_cnt == DIV_LAST);
  assign stop_low = active_q && low_q && (bit_idx == LAST_BIT);
  assign done     = stop_low && div_end;
  assign ps2_clk  = ~(active_q && low_q);
  assign ps2_data = active_q ? frame_q[0] : 1'b1;

  // Bit 0 of the shift register is always the bit on the wire; it shifts on
  // the low-to-high transition so data only moves at the start of a high phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      low_q    <= 1'b0;
      bit_idx  <= '0;
      div_cnt  <= '0;
      frame_q  <= '1;
    end else if (abort) begin
      active_q <= 1'b0;
      low_q    <= 1'b0;
      bit_idx  <= '0;
      div_cnt  <= '0;
      frame_q  <= '1;
    end else if (start) begin
      active_q <= 1'b1;
      low_q    <= 1'b0;
      bit_idx  <= '0;
      div_cnt  <= '0;
      frame_q  <= {1'b1, odd_parity(data), data, 1'b0};
    end else if (active_q) begin
      if (div_end) begin
        div_cnt <= '0;
        low_q   <= ~low_q;
        if (low_q) begin
          if (bit_idx == LAST_BIT) begin
            active_q <= 1'b0;
            low_q    <= 1'b0;
            bit_idx  <= '0;
            frame_q  <= '1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            frame_q <= {1'b1, frame_q[10:1]};
          end
        end
      end else begin
        div_cnt <= div_cnt + 12'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard event transmitter: turns make/break events into one or two
// frames, spaces frames with an idle gap and retransmits bytes cut off by host inhibit.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_release,
  output logic       key_ready,
  input  logic       ps2_inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] ev_count
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] gap_cnt;
  logic [7:0]  cur_code;
  logic        pending_break;
  logic [7:0]  cur_byte;
  logic        accept;
  logic        gap_last;
  logic        ser_start;
  logic        ser_abort;
  logic [7:0]  ser_data;
  logic        ser_stop_low;
  logic        ser_done;

  assign key_ready = rst && (state_q == ST_IDLE) && !ps2_inhibit;
  assign accept    = key_valid && key_ready;
  assign busy      = (state_q != ST_IDLE);
  assign cur_byte  = pending_break ? BREAK_CODE : cur_code;
  assign gap_last  = (gap_cnt == GAP_LAST);

  ps2_frame_ser #(
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .start   (ser_start),
    .abort   (ser_abort),
    .data    (ser_data),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .stop_low(ser_stop_low),
    .done    (ser_done)
  );

  // Once the stop bit's low phase has begun the frame counts as delivered,
  // so inhibit no longer aborts it.
  always_comb begin
    state_d   = state_q;
    ser_start = 1'b0;
    ser_abort = 1'b0;
    ser_data  = cur_byte;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ser_start = 1'b1;
          ser_data  = key_release ? BREAK_CODE : key_code;
          state_d   = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (ps2_inhibit && !ser_stop_low) begin
          ser_abort = 1'b1;
          state_d   = ST_HOLD;
        end else if (ser_done) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!ps2_inhibit && gap_last) begin
          if (pending_break) begin
            ser_start = 1'b1;
            ser_data  = cur_code;
            state_d   = ST_FRAME;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (!ps2_inhibit && gap_last) begin
          ser_start = 1'b1;
          state_d   = ST_FRAME;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Inhibit pauses the post-frame gap but restarts the post-abort hold wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if (state_d != state_q) begin
      gap_cnt <= '0;
    end else if (state_q == ST_HOLD && ps2_inhibit) begin
      gap_cnt <= '0;
    end else if ((state_q == ST_GAP || state_q == ST_HOLD) && !ps2_inhibit) begin
      gap_cnt <= gap_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_code      <= '0;
      pending_break <= 1'b0;
    end else if (accept) begin
      cur_code      <= key_code;
      pending_break <= key_release;
    end else if (state_q == ST_GAP && ser_start) begin
      pending_break <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_count <= '0;
    end else if (state_q == ST_FRAME && ser_done && !pending_break) begin
      ev_count <= ev_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: frames captured at each PS/2 clock fall
// are compared against frames built from the protocol rules.
module tb_ps2_kbd_tx;

  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 16;
  localparam int BIT_CYC = 2 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_release = 1'b0;
  logic       ps2_inhibit = 1'b0;
  logic       key_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] ev_count;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_ev = 8'h00;

  bit   bits_q[$];
  int   fall_cyc_q[$];
  int   cyc = 0;
  logic prev_clk = 1'b1;

  ps2_kbd_tx #(
    .CLK_DIV(CLK_DIV),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_release(key_release),
    .key_ready  (key_ready),
    .ps2_inhibit(ps2_inhibit),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .ev_count   (ev_count)
  );

  always #5 clk = ~clk;

  // The host samples data on each falling PS/2 clock edge.
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_clk <= ps2_clk;
    if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
      bits_q.push_back(ps2_data);
      fall_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  function automatic logic [21:0] grab(input int start);
    logic [21:0] v;
    v = '0;
    for (int i = 0; i < 22 && start + i < bits_q.size(); i++) v[i] = bits_q[start+i];
    return v;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      $display("[TB] FAIL %s idle_timeout busy=%b required=0", name, busy);
    end
  endtask

  task automatic wait_falls(input string name, input int target);
    int n;
    n = 0;
    while (bits_q.size() < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bits_q.size() < target) begin
      checks++;
      $display("[TB] FAIL %s fall_timeout falls=%0d required=%0d", name, bits_q.size(), target);
    end
  endtask

  task automatic send_event(input string name, input logic [7:0] code, input logic rel);
    int n;
    n = 0;
    @(negedge clk);
    while (key_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (key_ready !== 1'b1) begin
      checks++;
      $display("[TB] FAIL %s ready_timeout key_ready=%b required=1", name, key_ready);
    end
    key_valid   = 1'b1;
    key_code    = code;
    key_release = rel;
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2_clk, ps2_data, busy, key_ready, ev_count} !== {4'b1100, 8'h00}) begin
      $display("[TB] FAIL reset_state got clk=%b data=%b busy=%b rdy=%b ev=%h required 1 1 0 0 00",
               ps2_clk, ps2_data, busy, key_ready, ev_count);
    end else passes++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({key_ready, busy} !== 2'b10) begin
      $display("[TB] FAIL reset_release got rdy=%b busy=%b required rdy=1 busy=0", key_ready, busy);
    end else passes++;
  endtask

  task automatic test_make;
    int start, fstart, bad;
    start  = bits_q.size();
    fstart = fall_cyc_q.size();
    send_event("make", 8'h1C, 1'b0);
    @(negedge clk);
    checks++;
    if ({ps2_clk, ps2_data} !== 2'b10) begin
      $display("[TB] FAIL make_latency got clk=%b data=%b required clk=1 data=0", ps2_clk, ps2_data);
    end else passes++;
    wait_idle("make");
    exp_ev = exp_ev + 8'd1;
    checks++;
    if (bits_q.size() - start !== 11 || grab(start) !== {11'b0, frame_of(8'h1C)}) begin
      $display("[TB] FAIL make_bits got n=%0d bits=%b required n=11 bits=%b",
               bits_q.size() - start, grab(start), {11'b0, frame_of(8'h1C)});
    end else passes++;
    bad = 0;
    for (int i = 1; i < 11 && fstart + i < fall_cyc_q.size(); i++)
      if (fall_cyc_q[fstart+i] - fall_cyc_q[fstart+i-1] != BIT_CYC) bad++;
    checks++;
    if (bad !== 0) $display("[TB] FAIL make_spacing got bad_intervals=%0d required 0", bad);
    else passes++;
    checks++;
    if (ev_count !== exp_ev) $display("[TB] FAIL make_ev got %h required %h", ev_count, exp_ev);
    else passes++;
  endtask

  task automatic test_break;
    int start, fstart, gap;
    start  = bits_q.size();
    fstart = fall_cyc_q.size();
    send_event("break", 8'h1C, 1'b1);
    wait_falls("break", start + 12);
    checks++;
    if (ev_count !== exp_ev) $display("[TB] FAIL break_ev_early got %h required %h", ev_count, exp_ev);
    else passes++;
    wait_idle("break");
    exp_ev = exp_ev + 8'd1;
    checks++;
    if (bits_q.size() - start !== 22 || grab(start) !== {frame_of(8'h1C), frame_of(8'hF0)}) begin
      $display("[TB] FAIL break_bits got n=%0d bits=%b required n=22 bits=%b",
               bits_q.size() - start, grab(start), {frame_of(8'h1C), frame_of(8'hF0)});
    end else passes++;
    gap = (fall_cyc_q.size() > fstart + 11) ? fall_cyc_q[fstart+11] - fall_cyc_q[fstart+10] : -1;
    checks++;
    if (gap !== BIT_CYC + GAP_CYC)
      $display("[TB] FAIL break_gap got %0d required %0d", gap, BIT_CYC + GAP_CYC);
    else passes++;
    checks++;
    if (ev_count !== exp_ev) $display("[TB] FAIL break_ev got %h required %h", ev_count, exp_ev);
    else passes++;
  endtask

  task automatic test_random;
    int start, len;
    logic [7:0]  code;
    logic        rel;
    logic [21:0] want;
    for (int k = 0; k < 12; k++) begin
      code = 8'($urandom_range(0, 255));
      rel  = 1'($urandom_range(0, 1));
      want = rel ? {frame_of(code), frame_of(8'hF0)} : {11'b0, frame_of(code)};
      len  = rel ? 22 : 11;
      start = bits_q.size();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_event("random", code, rel);
      wait_idle("random");
      exp_ev = exp_ev + 8'd1;
      checks++;
      if (bits_q.size() - start !== len || grab(start) !== want) begin
        $display("[TB] FAIL random_bits code=%h rel=%b got n=%0d bits=%b required n=%0d bits=%b",
                 code, rel, bits_q.size() - start, grab(start), len, want);
      end else passes++;
      checks++;
      if (ev_count !== exp_ev) $display("[TB] FAIL random_ev got %h required %h", ev_count, exp_ev);
      else passes++;
    end
  endtask

  task automatic test_inhibit;
    int start, bad, n;
    logic [10:0] f;
    f = frame_of(8'h1C);
    start = bits_q.size();
    send_event("inhibit", 8'h1C, 1'b0);
    wait_falls("inhibit", start + 4);
    ps2_inhibit = 1'b1;
    @(negedge clk);
    checks++;
    if ({ps2_clk, ps2_data, busy} !== 3'b111) begin
      $display("[TB] FAIL inhibit_abort got clk=%b data=%b busy=%b required 1 1 1", ps2_clk, ps2_data, busy);
    end else passes++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({ps2_clk, ps2_data} !== 2'b11) bad++;
    end
    checks++;
    if (bad !== 0) $display("[TB] FAIL inhibit_hold got bad_cycles=%0d required 0", bad);
    else passes++;
    #1 ps2_inhibit = 1'b0;
    n = 0;
    while (bits_q.size() == start + 4 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== GAP_CYC + CLK_DIV)
      $display("[TB] FAIL inhibit_resume got %0d cycles required %0d", n, GAP_CYC + CLK_DIV);
    else passes++;
    wait_idle("inhibit");
    exp_ev = exp_ev + 8'd1;
    checks++;
    if (bits_q.size() - start !== 15 || grab(start) !== {7'b0, f, f[3:0]}) begin
      $display("[TB] FAIL inhibit_bits got n=%0d bits=%b required n=15 bits=%b",
               bits_q.size() - start, grab(start), {7'b0, f, f[3:0]});
    end else passes++;
    checks++;
    if (ev_count !== exp_ev) $display("[TB] FAIL inhibit_ev got %h required %h", ev_count, exp_ev);
    else passes++;
  endtask

  task automatic test_hold_valid;
    int start, bad, n;
    start = bits_q.size();
    send_event("hold_valid", 8'h1C, 1'b0);
    key_valid = 1'b1;
    key_code  = 8'h32;
    bad = 0;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 3000) begin
      if (key_ready !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad !== 0) $display("[TB] FAIL hold_ready_busy got bad_cycles=%0d required 0", bad);
    else passes++;
    checks++;
    if (key_ready !== 1'b1) $display("[TB] FAIL hold_ready_idle got %b required 1", key_ready);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL hold_accept got busy=%b required 1", busy);
    else passes++;
    key_valid = 1'b0;
    wait_idle("hold_valid");
    exp_ev = exp_ev + 8'd2;
    checks++;
    if (bits_q.size() - start !== 22 || grab(start) !== {frame_of(8'h32), frame_of(8'h1C)}) begin
      $display("[TB] FAIL hold_bits got n=%0d bits=%b required n=22 bits=%b",
               bits_q.size() - start, grab(start), {frame_of(8'h32), frame_of(8'h1C)});
    end else passes++;
    checks++;
    if (ev_count !== exp_ev) $display("[TB] FAIL hold_ev got %h required %h", ev_count, exp_ev);
    else passes++;
  endtask

  task automatic test_reset_mid;
    int start;
    start = bits_q.size();
    send_event("reset_mid", 8'h55, 1'b0);
    wait_falls("reset_mid", start + 3);
    rst = 1'b0;
    #1;
    exp_ev = 8'h00;
    checks++;
    if ({ps2_clk, ps2_data, busy, ev_count} !== {3'b110, 8'h00}) begin
      $display("[TB] FAIL reset_mid_state got clk=%b data=%b busy=%b ev=%h required 1 1 0 00",
               ps2_clk, ps2_data, busy, ev_count);
    end else passes++;
    @(negedge clk);
    rst = 1'b1;
    repeat (150) @(negedge clk);
    checks++;
    if (bits_q.size() - start !== 3 || busy !== 1'b0) begin
      $display("[TB] FAIL reset_mid_quiet got falls=%0d busy=%b required falls=3 busy=0",
               bits_q.size() - start, busy);
    end else passes++;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 256; i++) begin
      send_event("wrap", 8'($urandom_range(0, 255)), 1'b0);
      wait_idle("wrap");
      exp_ev = exp_ev + 8'd1;
      if (i == 254) begin
        checks++;
        if (ev_count !== exp_ev) $display("[TB] FAIL wrap_ff got %h required %h", ev_count, exp_ev);
        else passes++;
      end
    end
    checks++;
    if (ev_count !== exp_ev) $display("[TB] FAIL wrap_00 got %h required %h", ev_count, exp_ev);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_random();
    test_inhibit();
    test_hold_valid();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per PS/2 clock half-period (range 2..4095).
REQ-002 Parameter GAP_CYC, default 16: idle system clocks between consecutive frames (range 1..65535).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 key_valid  input  1  key event offered.
REQ-006 key_code  input  8  scancode of the event.
REQ-007 key_release  input  1  1 = break event, 0 = make event.
REQ-008 key_ready  output  1  block accepts an event this cycle.
REQ-009 ps2_inhibit  input  1  host holds the PS/2 clock low (synchronous, already synchronized).
REQ-010 ps2_clk  output  1  device-driven PS/2 clock; idle high.
REQ-011 ps2_data  output  1  device-driven PS/2 data; idle high.
REQ-012 busy  output  1  an event is in progress (any state other than IDLE).
REQ-013 ev_count  output  8  count of completed events; wraps 0xFF -> 0x00.

Function
REQ-014 Handshake: an event is accepted when key_valid && key_ready are high on the same edge; key_code and key_release are latched then.
REQ-015 key_ready = 1 only in IDLE with ps2_inhibit = 0; in every other state key_valid is ignored and no event is queued.
REQ-016 A make event transmits one frame: key_code. A break event transmits two frames: 0xF0, then key_code.
REQ-017 Frame = 11 bits in order: start 0, data bits 0..7 LSB first, odd parity (data ones + parity = odd), stop 1.
REQ-018 Bit period = CLK_DIV cycles with ps2_clk = 1, then CLK_DIV cycles with ps2_clk = 0; ps2_data changes only on the first cycle of the high phase and is held stable through the low phase.
REQ-019 Latency: the first high phase of the start bit begins the cycle after acceptance; ps2_data goes 0 on that cycle.
REQ-020 After the stop bit's low phase: ps2_clk = 1, ps2_data = 1 for GAP_CYC cycles (GAP state), then next frame or IDLE.
REQ-021 States: IDLE, FRAME, GAP, HOLD. IDLE->FRAME on accept; FRAME->GAP after bit 10; GAP->FRAME if the 0xF0 prefix was just sent, else GAP->IDLE; FRAME->HOLD on inhibit; HOLD->FRAME on release.
REQ-022 ps2_inhibit = 1 during FRAME before the stop bit's low phase starts: abort within 1 cycle, drive ps2_clk = ps2_data = 1, enter HOLD; after inhibit deasserts, wait GAP_CYC cycles, then retransmit the whole current byte from the start bit.
REQ-023 ps2_inhibit = 1 during the stop bit's low phase or GAP: the frame is complete and is not resent; progression pauses until release.
REQ-024 ev_count increments by 1 on the cycle the final frame of an event enters GAP; busy falls on the return to IDLE.

Reset
REQ-025 While rst = 0: state IDLE, ps2_clk = 1, ps2_data = 1, busy = 0, ev_count = 0x00, key_ready = 0, divider and bit counters cleared.
REQ-026 Reset mid-frame drops the event with no resend; key_ready = 1 on the first edge after rst rises if ps2_inhibit = 0.

Structure
REQ-027 Package ps2_pkg holds the state enum, BREAK_CODE = 8'hF0, FRAME_BITS = 11, and a function that computes odd parity.
REQ-028 Sub-module ps2_frame_ser performs byte-to-11-bit serialization and clock-phase timing (start/abort in, done out); ps2_kbd_tx holds the event FSM, gap timer, and counter.

Verification
REQ-029 Make 0x1C with CLK_DIV = 4: ps2_data sampled at each ps2_clk falling edge = 0,0,0,1,1,1,0,0,0,0,1; 11 falling edges 8 cycles apart; ev_count 0 -> 1.
REQ-030 Break 0x1C: frame 0xF0 (data 0,0,0,0,1,1,1,1, parity 1), exactly GAP_CYC idle cycles, then frame 0x1C; ev_count +1 only after the second frame.
REQ-031 Assert ps2_inhibit after the 4th falling edge of 0x1C: lines high within 1 cycle; on release plus GAP_CYC cycles, a full 11-bit 0x1C frame is retransmitted.
REQ-032 Hold key_valid high with 0x32 while busy: key_ready = 0 and no extra frame is sent; 0x32 is accepted on the first IDLE cycle.
REQ-033 Assert rst mid-frame: ps2_clk = ps2_data = 1 and ev_count = 0 immediately; no frame follows until a new accept.
REQ-034 Send 256 make events: ev_count wraps to 0x00.
